// File: rtl/tst_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tst_bus_pkg
// Description : Shared types, constants and helpers for the tst_bus peer.
// Revision    : 1.0 - initial release
// ============================================================================
package tst_bus_pkg;

    // Peer controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_TURN = 3'd2,
        ST_RD   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    // Width of one bus beat
    localparam int NIBW = 4;

    // Number of nibble beats needed to carry a dw-bit word
    function automatic int nbeats(input int dw);
        return (dw + NIBW - 1) / NIBW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tst_bus_iobuf.sv
`default_nettype none
// ============================================================================
// Module      : tst_bus_iobuf
// Description : 5-bit tri-state pad buffer for the io strobe and vio nibble.
//               Bit 4 maps to io, bits 3..0 map to vio[0]..vio[3].
// Revision    : 1.0 - initial release
// ============================================================================
import tst_bus_pkg::*;

module tst_bus_iobuf (
    input  logic            oe,
    input  logic [4:0]      o,
    output logic [4:0]      i,
    inout  wire             io,
    inout  wire  [0:NIBW-1] vio
);

    // Strobe pin
    assign io   = oe ? o[4] : 1'bz;
    assign i[4] = io;

    // Nibble pins: vio[0] carries the nibble MSB
    for (genvar k = 0; k < NIBW; k++) begin : g_vio
        assign vio[k]           = oe ? o[NIBW-1-k] : 1'bz;
        assign i[NIBW-1-k]      = vio[k];
    end

endmodule
`default_nettype wire

// File: rtl/tst_bus_peer.sv
`default_nettype none
// ============================================================================
// Module      : tst_bus_peer
// Description : Far-end partner for the io/vio inout pair. Serializes write
//               words onto vio in nibbles strobed by io, and deserializes read
//               words with a per-beat timeout.
// Revision    : 1.0 - initial release
// ============================================================================
import tst_bus_pkg::*;

module tst_bus_peer #(
    parameter int V2KPARAM = 5,
    parameter int TURN     = 1,
    parameter int TMO      = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [V2KPARAM:0]   req_data,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [V2KPARAM:0]   rsp_data,
    inout  wire                 io,
    inout  wire  [0:NIBW-1]     vio
);

    localparam int c_dw = V2KPARAM + 1;
    localparam int c_nb = nbeats(c_dw);
    localparam int c_pw = c_nb * NIBW;
    localparam int c_bw = (c_nb > 1) ? $clog2(c_nb) : 1;

    localparam logic [c_bw-1:0] c_last_beat = c_bw'(c_nb - 1);
    localparam logic [7:0]      c_turn_last = 8'(TURN - 1);
    localparam logic [7:0]      c_tmo_last  = 8'(TMO - 1);

    state_t             r_state, w_state_nx;
    logic [c_bw-1:0]    r_beat, w_beat_nx;
    logic [7:0]         r_cnt, w_cnt_nx;
    logic [c_pw-1:0]    r_shift, w_shift_nx;
    logic               r_oe, w_oe_nx;
    logic [4:0]         r_out, w_out_nx;
    logic               r_req_ready, w_req_ready_nx;
    logic               r_rsp_valid, w_rsp_valid_nx;
    logic               r_rsp_err, w_rsp_err_nx;
    logic [c_dw-1:0]    r_rsp_data, w_rsp_data_nx;

    logic [4:0]         w_in;
    logic [c_pw-1:0]    w_pad;
    logic [c_pw-1:0]    w_acc;
    logic               w_strobe;

    // Pad buffer: the only place the bus is driven or released
    tst_bus_iobuf u_iobuf (
        .oe  (r_oe),
        .o   (r_out),
        .i   (w_in),
        .io  (io),
        .vio (vio)
    );

    // Only a clean 1 on io counts as a beat; X/Z/0 are ignored
    assign w_strobe = (w_in[4] == 1'b1);
    // Write word zero-padded to a whole number of nibbles
    assign w_pad    = c_pw'(req_data);
    // Read accumulator: new nibble enters at the top, so the first beat ends lowest
    assign w_acc    = (r_shift >> NIBW) | (c_pw'(w_in[NIBW-1:0]) << (c_pw - NIBW));

    // Next-state and next-output logic
    always_comb begin
        w_state_nx     = r_state;
        w_beat_nx      = r_beat;
        w_cnt_nx       = r_cnt;
        w_shift_nx     = r_shift;
        w_oe_nx        = r_oe;
        w_out_nx       = r_out;
        w_req_ready_nx = r_req_ready;
        w_rsp_valid_nx = 1'b0;
        w_rsp_err_nx   = r_rsp_err;
        w_rsp_data_nx  = r_rsp_data;

        case (r_state)
            ST_IDLE: begin
                w_req_ready_nx = 1'b1;
                w_oe_nx        = 1'b0;
                if (req_valid && r_req_ready) begin
                    w_req_ready_nx = 1'b0;
                    w_beat_nx      = '0;
                    w_cnt_nx       = '0;
                    if (req_write) begin
                        w_out_nx   = {1'b1, w_pad[NIBW-1:0]};
                        w_oe_nx    = 1'b1;
                        w_shift_nx = w_pad >> NIBW;
                        w_state_nx = ST_WR;
                    end else begin
                        w_shift_nx = '0;
                        w_state_nx = ST_TURN;
                    end
                end
            end

            ST_WR: begin
                if (r_beat == c_last_beat) begin
                    w_oe_nx        = 1'b0;
                    w_out_nx       = '0;
                    w_req_ready_nx = 1'b1;
                    w_state_nx     = ST_IDLE;
                end else begin
                    w_out_nx   = {1'b1, r_shift[NIBW-1:0]};
                    w_shift_nx = r_shift >> NIBW;
                    w_beat_nx  = r_beat + 1'b1;
                end
            end

            ST_TURN: begin
                if (r_cnt == c_turn_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_RD;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end

            ST_RD: begin
                if (w_strobe) begin
                    w_shift_nx = w_acc;
                    w_cnt_nx   = '0;
                    if (r_beat == c_last_beat) begin
                        w_rsp_valid_nx = 1'b1;
                        w_rsp_err_nx   = 1'b0;
                        w_rsp_data_nx  = w_acc[c_dw-1:0];
                        w_state_nx     = ST_RSP;
                    end else begin
                        w_beat_nx = r_beat + 1'b1;
                    end
                end else if (r_cnt == c_tmo_last) begin
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_err_nx   = 1'b1;
                    w_rsp_data_nx  = '0;
                    w_state_nx     = ST_RSP;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end

            ST_RSP: begin
                w_req_ready_nx = 1'b1;
                w_state_nx     = ST_IDLE;
            end

            default: begin
                w_oe_nx    = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_oe        <= 1'b0;
            r_out       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_beat      <= w_beat_nx;
            r_cnt       <= w_cnt_nx;
            r_shift     <= w_shift_nx;
            r_oe        <= w_oe_nx;
            r_out       <= w_out_nx;
            r_req_ready <= w_req_ready_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_err   <= w_rsp_err_nx;
            r_rsp_data  <= w_rsp_data_nx;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
